// File: rtl/bike_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bike_pkg
// Description : Shared definitions for the shared divider slice.
//               WIDTH_DIV  - default operand/result width.
//               div_state_e - sequencer states (IDLE, CALC, DONE).
// Revision    : 1.0 - initial release
// ============================================================================
package bike_pkg;

    localparam int WIDTH_DIV = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : bike_pkg
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Iterative unsigned radix-2 restoring divider datapath.
//               One quotient bit per step, MSB first. Results are registered
//               on the final step only and hold until the next final step.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_load            - capture i_dividend/i_divisor, clear state
//               i_step            - perform one iteration
//               i_dividend/i_divisor - operands (WIDTH)
//               o_last            - iteration counter is on the final step
//               o_quotient/o_remainder - result registers (WIDTH)
//               o_div_zero        - last completed division had divisor 0
// Revision    : 1.0 - initial release
// ============================================================================
module div_core
    import bike_pkg::*;
#(
    parameter int WIDTH = WIDTH_DIV,
    parameter int N_CYC = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_last,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int                 c_CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N_CYC - 1);

    logic [WIDTH-1:0]   r_rem;   // partial remainder, always < divisor
    logic [WIDTH-1:0]   r_dvd;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_shift; // shifted partial remainder, one bit wider
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_unused;

    assign o_last    = (r_cnt == c_LAST);

    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    // After a successful subtract the result is below the divisor, and when
    // the subtract is skipped the shifted value is already below it, so the
    // kept remainder always fits in WIDTH bits. A zero divisor subtracts
    // every step, giving all-ones quotient and remainder equal to dividend.
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_unused  = w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else if (i_load) begin
            r_rem <= '0;
            r_dvd <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
        end else if (i_step) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_last) begin
                o_quotient  <= w_quo_nxt;
                o_remainder <= w_rem_nxt;
                o_div_zero  <= (r_dvs == '0);
            end
        end
    end

endmodule : div_core
`default_nettype wire

// File: rtl/shared_divider.sv
`default_nettype none
// ============================================================================
// Module      : shared_divider
// Description : One iterative unsigned divider shared by two clients.
//               Requests are held in per-client pending flags and granted
//               round-robin from IDLE; the datapath lives in div_core.
// Ports       : clk, rst                   - clock, sync active-high reset
//               start0, dividend0, divisor0 - client 0 request + operands
//               start1, dividend1, divisor1 - client 1 request + operands
//               busy      - division in progress (CALC)
//               ready     - one-cycle result-valid pulse (DONE)
//               owner     - client of the current/last result
//               quotient, remainder, div_zero - result of last division
// Revision    : 1.0 - initial release
// ============================================================================
module shared_divider
    import bike_pkg::*;
#(
    parameter int WIDTH = WIDTH_DIV,
    parameter int N_CYC = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             start1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             busy,
    output logic             ready,
    output logic             owner,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e r_state;
    div_state_e w_state_nxt;

    logic             r_pend0;
    logic             r_pend1;
    logic             r_prio;     // client that wins a simultaneous request
    logic             r_owner;

    logic             w_req0;
    logic             w_req1;
    logic             w_gnt_sel;
    logic             w_load;
    logic             w_last;
    logic             w_serving0;
    logic             w_serving1;
    logic             w_pend0_nxt;
    logic             w_pend1_nxt;
    logic [WIDTH-1:0] w_ld_dividend;
    logic [WIDTH-1:0] w_ld_divisor;

    // A start in the grant cycle itself is served directly, not queued.
    assign w_req0    = r_pend0 | start0;
    assign w_req1    = r_pend1 | start1;
    assign w_gnt_sel = (w_req0 && w_req1) ? r_prio : w_req1;

    assign w_ld_dividend = w_gnt_sel ? dividend1 : dividend0;
    assign w_ld_divisor  = w_gnt_sel ? divisor1  : divisor0;

    // A client whose job is in flight (CALC or DONE) cannot queue a second one.
    assign w_serving0 = (r_state != IDLE) && !r_owner;
    assign w_serving1 = (r_state != IDLE) &&  r_owner;

    assign w_pend0_nxt = (w_load && !w_gnt_sel)   ? 1'b0 :
                         (start0 && !w_serving0)  ? 1'b1 : r_pend0;
    assign w_pend1_nxt = (w_load &&  w_gnt_sel)   ? 1'b0 :
                         (start1 && !w_serving1)  ? 1'b1 : r_pend1;

    assign busy  = (r_state == CALC);
    assign ready = (r_state == DONE);
    assign owner = r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_pend0 <= w_pend0_nxt;
            r_pend1 <= w_pend1_nxt;
            if (w_load) begin
                r_owner <= w_gnt_sel;
                r_prio  <= ~w_gnt_sel;
            end
        end
    end

    div_core #(
        .WIDTH (WIDTH),
        .N_CYC (N_CYC)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (busy),
        .i_dividend  (w_ld_dividend),
        .i_divisor   (w_ld_divisor),
        .o_last      (w_last),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

endmodule : shared_divider
`default_nettype wire

// File: tb/tb_shared_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_divider
// Description : Directed self-checking bench for shared_divider. Expected
//               results come from a reference model and are queued when a
//               request is driven, then popped when ready pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_divider;

    localparam int c_W = 16;

    typedef struct packed {
        logic           owner;
        logic [c_W-1:0] quo;
        logic [c_W-1:0] rem;
        logic           dz;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start0;
    logic [c_W-1:0] dividend0;
    logic [c_W-1:0] divisor0;
    logic           start1;
    logic [c_W-1:0] dividend1;
    logic [c_W-1:0] divisor1;
    logic           busy;
    logic           ready;
    logic           owner;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_zero;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    shared_divider #(
        .WIDTH (c_W),
        .N_CYC (c_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start0    (start0),
        .dividend0 (dividend0),
        .divisor0  (divisor0),
        .start1    (start1),
        .dividend1 (dividend1),
        .divisor1  (divisor1),
        .busy      (busy),
        .ready     (ready),
        .owner     (owner),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic own, input logic [c_W-1:0] a,
                                   input logic [c_W-1:0] b);
        exp_t e;
        e.owner = own;
        if (b == '0) begin
            e.quo = '1;
            e.rem = a;
            e.dz  = 1'b1;
        end else begin
            e.quo = a / b;
            e.rem = a % b;
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic cl, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        if (cl) begin
            start1 = 1'b1; dividend1 = a; divisor1 = b;
        end else begin
            start0 = 1'b1; dividend0 = a; divisor0 = b;
        end
    endtask

    task automatic clr_starts();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Entered in the first cycle after the reference edge (cycle 1).
    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
        int   c;
        int   nb;
        exp_t e;
        c  = 1;
        nb = 0;
        while (!ready && c < 100) begin
            if (busy) nb++;
            tick();
            c++;
        end
        chk({tag, "_latency"}, c, exp_lat);
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_busy_at_ready"}, busy, 1'b0);
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_owner"},     owner,     e.owner);
            chk({tag, "_quotient"},  quotient,  e.quo);
            chk({tag, "_remainder"}, remainder, e.rem);
            chk({tag, "_div_zero"},  div_zero,  e.dz);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            if (ready || busy) hits++;
            tick();
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; dividend0 = '0; divisor0 = '0;
        start1 = 1'b0; dividend1 = '0; divisor1 = '0;
        tick();
        tick();
        chk("rst_busy",      busy,      1'b0);
        chk("rst_ready",     ready,     1'b0);
        chk("rst_owner",     owner,     1'b0);
        chk("rst_quotient",  quotient,  16'd0);
        chk("rst_remainder", remainder, 16'd0);
        chk("rst_div_zero",  div_zero,  1'b0);
        rst = 1'b0;
        tick();

        // Client 0: 36000 / 10
        drive_req(1'b0, 16'd36000, 16'd10);
        sb.push_back(model(1'b0, 16'd36000, 16'd10));
        tick();
        clr_starts();
        wait_result("c0_basic", 17, 16);
        tick();
        chk("hold_ready",    ready,    1'b0);
        chk("hold_quotient", quotient, 16'd3600);

        // Client 1: divide by zero
        drive_req(1'b1, 16'd1234, 16'd0);
        sb.push_back(model(1'b1, 16'd1234, 16'd0));
        tick();
        clr_starts();
        wait_result("c1_divzero", 17, 16);
        tick();

        // Simultaneous requests right after reset: client 0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_req(1'b0, 16'd100, 16'd7);
        drive_req(1'b1, 16'd65535, 16'd1);
        sb.push_back(model(1'b0, 16'd100, 16'd7));
        sb.push_back(model(1'b1, 16'd65535, 16'd1));
        tick();
        clr_starts();
        wait_result("both_first", 17, 16);
        tick();
        wait_result("both_second", 18, 16);
        tick();

        // Client 1 arrives mid-CALC; repeated starts are absorbed
        drive_req(1'b0, 16'd1000, 16'd3);
        sb.push_back(model(1'b0, 16'd1000, 16'd3));
        tick();
        clr_starts();
        repeat (5) tick();
        drive_req(1'b1, 16'd7, 16'd65535);
        sb.push_back(model(1'b1, 16'd7, 16'd65535));
        tick();
        clr_starts();
        drive_req(1'b0, 16'd111, 16'd1);
        tick();
        clr_starts();
        drive_req(1'b1, 16'd7, 16'd65535);
        tick();
        clr_starts();
        wait_result("mid_c0", 9, 8);
        tick();
        wait_result("mid_c1", 18, 16);
        tick();
        quiet("absorbed_no_extra_job", 20);

        // Reset on the 8th busy cycle
        drive_req(1'b0, 16'd60000, 16'd7);
        tick();
        clr_starts();
        repeat (7) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_busy",      busy,      1'b0);
        chk("midrst_ready",     ready,     1'b0);
        chk("midrst_owner",     owner,     1'b0);
        chk("midrst_quotient",  quotient,  16'd0);
        chk("midrst_remainder", remainder, 16'd0);
        chk("midrst_div_zero",  div_zero,  1'b0);
        rst = 1'b0;
        quiet("midrst_no_ready", 20);
        drive_req(1'b0, 16'd50, 16'd5);
        sb.push_back(model(1'b0, 16'd50, 16'd5));
        tick();
        clr_starts();
        wait_result("after_rst", 17, 16);
        tick();

        // Operands change during CALC
        drive_req(1'b0, 16'd1000, 16'd7);
        sb.push_back(model(1'b0, 16'd1000, 16'd7));
        tick();
        clr_starts();
        dividend0 = 16'd9999;
        divisor0  = 16'd3;
        wait_result("latched_ops", 17, 16);
        tick();

        // Client 0 served last: client 1 wins the tie
        drive_req(1'b0, 16'd20, 16'd3);
        drive_req(1'b1, 16'd21, 16'd4);
        sb.push_back(model(1'b1, 16'd21, 16'd4));
        sb.push_back(model(1'b0, 16'd20, 16'd3));
        tick();
        clr_starts();
        wait_result("rr_first", 17, 16);
        tick();
        wait_result("rr_second", 18, 16);
        tick();

        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shared_divider
`default_nettype wire

// File: doc/shared_divider.md
SHARED_DIVIDER -- requirements
Module: shared_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter N_CYC, default WIDTH, meaning iterations per division (fixed equal to WIDTH).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start0  input  1  client-0 request pulse; operands valid on dividend0/divisor0 while pending.
REQ-006 dividend0, divisor0  input  WIDTH each  client-0 operands.
REQ-007 start1  input  1  client-1 request pulse.
REQ-008 dividend1, divisor1  input  WIDTH each  client-1 operands.
REQ-009 busy  output  1  division in progress.
REQ-010 ready  output  1  one-cycle pulse, result valid.
REQ-011 owner  output  1  client index of current/last result.
REQ-012 quotient, remainder  output  WIDTH each  unsigned result.
REQ-013 div_zero  output  1  last division had divisor 0.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; unsigned radix-2 restoring division, one quotient bit per CALC cycle, MSB first.
REQ-015 SHALL hold per-client pending flags: set by startN in any state, cleared when that client is granted.
REQ-016 In IDLE with any pending/start asserted, SHALL grant one client, latch its dividend/divisor that cycle, set owner, go to CALC.
REQ-017 Both clients requesting simultaneously SHALL be resolved round-robin: client not served last wins; after reset client 0 wins.
REQ-018 busy SHALL be 1 exactly during CALC: start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH, DONE/ready=1 at cycle k+WIDTH+1, busy=0 in that cycle.
REQ-019 quotient, remainder, div_zero SHALL update only on entry to DONE and hold until next DONE.
REQ-020 DONE SHALL last one cycle, then IDLE; a pending request SHALL be granted in that IDLE cycle (back-to-back gap exactly one IDLE cycle).
REQ-021 divisor 0 SHALL complete with normal latency: quotient all-ones, remainder = dividend, div_zero=1.
REQ-022 startN repeated while that client is pending or being served SHALL be absorbed (no second queued request for same client).
REQ-023 Operands SHALL be sampled only at grant; later changes on client inputs SHALL not affect the running division.
REQ-024 Internal partial remainder SHALL be WIDTH+1 bits; no overflow for any WIDTH-bit operands.

Reset
REQ-025 rst SHALL, in any state including mid-CALC, force IDLE next cycle: busy=0, ready=0, owner=0, quotient=0, remainder=0, div_zero=0, pending flags cleared, round-robin pointer to client 0.
REQ-026 A division interrupted by rst SHALL produce no ready pulse.

Structure
REQ-027 Shared package bike_pkg SHALL hold WIDTH_DIV=16 and the state enumeration (IDLE, CALC, DONE).
REQ-028 Iterative datapath SHALL be sub-module div_core (load, step, quotient/remainder registers, iteration counter); arbitration, pending flags and FSM in shared_divider.

Verification
REQ-029 Client 0: 36000/10 at edge k -> busy k+1..k+16, ready at k+17, quotient 3600, remainder 0, owner 0, div_zero 0.
REQ-030 Client 1: 1234/0 -> after 17 cycles quotient 0xFFFF, remainder 1234, div_zero 1, owner 1.
REQ-031 After reset, start0 and start1 same cycle (100/7, 65535/1) -> ready with owner 0 (14 r2), one IDLE cycle, then ready owner 1 (65535 r0).
REQ-032 start1 (7/65535) asserted mid-CALC of client-0 job -> client-0 result first, client-1 result 18 cycles later: quotient 0, remainder 7.
REQ-033 rst asserted at 8th busy cycle -> busy 0 next cycle, no ready, outputs 0; new start0 50/5 afterwards gives 10 r0 with normal latency.
REQ-034 Changing dividend0 during CALC -> result reflects operands latched at grant.
